// File: rtl/mr1_dmem_slave_pkg.sv
// Shared constants, state encoding and lane/alignment helpers for the MR1 data-memory slave.
package mr1_mem_pkg;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

  typedef enum logic {ST_RUN, ST_STALL} stall_st_e;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      MEM_SIZE_B: return 4'b0001 << addr_lo;
      MEM_SIZE_H: return 4'b0011 << addr_lo;
      MEM_SIZE_W: return 4'b1111 << addr_lo;
      default:    return 4'b0000;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      MEM_SIZE_B: return 1'b0;
      MEM_SIZE_H: return addr_lo[0];
      MEM_SIZE_W: return |addr_lo;
      default:    return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mr1_dmem_slave_if.sv
// Core data-port bus between the MR1 master and the data-memory slave.
interface mr1_dmem_slave_if;
  logic        data_req_valid;
  logic        data_req_ready;
  logic        data_req_wr;
  logic [1:0]  data_req_size;
  logic [31:0] data_req_addr;
  logic [31:0] data_req_data;
  logic        data_rsp_valid;
  logic [31:0] data_rsp_data;
  logic        err_misaligned;

  modport master (
    output data_req_valid, data_req_wr, data_req_size, data_req_addr, data_req_data,
    input  data_req_ready, data_rsp_valid, data_rsp_data, err_misaligned
  );

  modport slave (
    input  data_req_valid, data_req_wr, data_req_size, data_req_addr, data_req_data,
    output data_req_ready, data_rsp_valid, data_rsp_data, err_misaligned
  );
endinterface

// File: rtl/mr1_dmem_slave_delay.sv
// Fixed-latency load-response pipe; valid bits clear on reset, data stages only load behind a valid.
module mr1_rsp_delay_line #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        out_valid,
  output logic [31:0] out_data
);

  logic [LATENCY-1:0]       vld_q;
  logic [LATENCY-1:0][31:0] dat_q;
  logic [LATENCY:0]         vld_pipe;
  logic [LATENCY:0][31:0]   dat_pipe;

  assign vld_pipe = {vld_q, in_valid};
  assign dat_pipe = {dat_q, in_data};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_pipe[LATENCY-1:0];

  // Stages hold their word when no load passes, so the output keeps the last response.
  always_ff @(posedge clk)
    for (int i = 0; i < LATENCY; i++)
      if (vld_pipe[i]) dat_q[i] <= dat_pipe[i];

  assign out_valid = vld_pipe[LATENCY];
  assign out_data  = dat_pipe[LATENCY];

endmodule

// File: rtl/mr1_dmem_slave.sv
// Behavioural data-memory slave for the MR1 data port: byte-lane RAM, fixed load latency,
// optional periodic back-pressure and a sticky misalignment flag.
module mr1_dmem_slave
  import mr1_mem_pkg::*;
#(
  parameter int ADDR_BITS    = 10,
  parameter int LATENCY      = 1,
  parameter int STALL_PERIOD = 0
) (
  input logic             clk,
  input logic             reset,
  mr1_dmem_slave_if.slave bus
);

  localparam int CW      = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  localparam int LAST_I  = (STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = LAST_I[CW-1:0];

  logic [31:0]          mem [0:(1<<ADDR_BITS)-1];
  logic [ADDR_BITS-1:0] widx;
  logic [1:0]           alo;
  logic [3:0]           be;
  logic [31:0]          wdata;
  logic                 acc, mis;
  logic                 ready_q, err_q, seen_q;
  stall_st_e            st_q;
  logic [CW-1:0]        cnt_q;
  logic                 dl_vld;
  logic [31:0]          dl_dat;

  // Upper address bits alias the RAM image.
  wire unused_addr_hi = ^bus.data_req_addr[31:ADDR_BITS+2];

  assign widx  = bus.data_req_addr[ADDR_BITS+1:2];
  assign alo   = bus.data_req_addr[1:0];
  assign be    = byte_en(bus.data_req_size, alo);
  assign mis   = is_misaligned(bus.data_req_size, alo);
  assign wdata = bus.data_req_data << {alo, 3'b000};
  assign acc   = bus.data_req_valid & ready_q;

  always_ff @(posedge clk)
    if (acc && bus.data_req_wr && !mis)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];

  // A load never shares an edge with a store, so the current word already has all prior writes.
  mr1_rsp_delay_line #(.LATENCY(LATENCY)) u_dly (
    .clk      (clk),
    .rst_n    (reset),
    .in_valid (acc & ~bus.data_req_wr),
    .in_data  (mem[widx]),
    .out_valid(dl_vld),
    .out_data (dl_dat)
  );

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st_q    <= ST_RUN;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (st_q)
        ST_RUN: begin
          ready_q <= 1'b1;
          if (acc) begin
            if (STALL_PERIOD != 0 && cnt_q == CNT_LAST) begin
              st_q    <= ST_STALL;
              cnt_q   <= '0;
              ready_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_STALL: begin
          st_q    <= ST_RUN;
          ready_q <= 1'b1;
        end
        default: begin
          st_q    <= ST_RUN;
          ready_q <= 1'b0;
        end
      endcase
    end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      err_q  <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      if (acc && mis) err_q <= 1'b1;
      if (dl_vld)     seen_q <= 1'b1;
    end

  // Delay-line data is not reset; mask stale words until the first post-reset response.
  assign bus.data_req_ready = ready_q;
  assign bus.data_rsp_valid = dl_vld;
  assign bus.data_rsp_data  = (seen_q | dl_vld) ? dl_dat : 32'h0;
  assign bus.err_misaligned = err_q;

endmodule

// File: tb/tb_mr1_dmem_slave.sv
// Randomized + directed bench for mr1_dmem_slave against a byte-addressed reference model.
module tb_mr1_dmem_slave;

  localparam int AB  = 10;
  localparam int LAT = 3;
  localparam int SP  = 2;
  localparam int unsigned MASK = (4 << AB) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mr1_dmem_slave_if bus();

  mr1_dmem_slave #(.ADDR_BITS(AB), .LATENCY(LAT), .STALL_PERIOD(SP)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct { int due; logic [31:0] data; bit known; } exp_t;
  typedef struct { logic [31:0] data; int cyc; } obs_t;

  int nchk = 0, nerr = 0;
  int tcyc = 0;
  exp_t rq[$];
  obs_t obs_a[$];
  logic [7:0] mb [int];
  bit exp_ready = 0, exp_v = 0, exp_err = 0, dknown = 1;
  logic [31:0] exp_data = 0;
  int acc_cnt = 0;
  logic [31:0] rdy_log = 0;
  int rdy_n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit mis_rule(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
  endfunction

  // Reference: memory as bytes, ready from accept count, responses scheduled by due cycle.
  always @(posedge clk) begin
    bit acc, nxt;
    tcyc++;
    if (!reset) begin
      rq.delete();
      exp_ready = 0; exp_v = 0; exp_data = 0; dknown = 1; exp_err = 0; acc_cnt = 0;
    end else begin
      acc = bus.data_req_valid && exp_ready;
      nxt = 1;
      if (acc) begin
        int unsigned a, w;
        exp_t e;
        acc_cnt++;
        if (SP != 0 && acc_cnt % SP == 0) nxt = 0;
        a = bus.data_req_addr & MASK;
        if (mis_rule(bus.data_req_size, bus.data_req_addr)) exp_err = 1;
        if (bus.data_req_wr) begin
          if (!mis_rule(bus.data_req_size, bus.data_req_addr))
            for (int i = 0; i < (1 << bus.data_req_size); i++)
              mb[a + i] = bus.data_req_data[8*i +: 8];
        end else begin
          w = a & ~32'd3;
          e.due = tcyc + LAT - 1;
          e.known = mb.exists(w) && mb.exists(w+1) && mb.exists(w+2) && mb.exists(w+3);
          e.data = e.known ? {mb[w+3], mb[w+2], mb[w+1], mb[w]} : 32'h0;
          rq.push_back(e);
        end
      end
      exp_ready = nxt;
      exp_v = 0;
      if (rq.size() > 0 && rq[0].due == tcyc) begin
        exp_v = 1;
        dknown = rq[0].known;
        if (rq[0].known) exp_data = rq[0].data;
        void'(rq.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_ready", {31'b0, bus.data_req_ready}, 0);
      chk("rst_rsp_valid", {31'b0, bus.data_rsp_valid}, 0);
      chk("rst_rsp_data", bus.data_rsp_data, 0);
      chk("rst_err", {31'b0, bus.err_misaligned}, 0);
    end else begin
      chk("ready", {31'b0, bus.data_req_ready}, {31'b0, exp_ready});
      chk("rsp_valid", {31'b0, bus.data_rsp_valid}, {31'b0, exp_v});
      if (dknown) chk("rsp_data", bus.data_rsp_data, exp_data);
      chk("err", {31'b0, bus.err_misaligned}, {31'b0, exp_err});
      if (bus.data_rsp_valid) obs_a.push_back('{bus.data_rsp_data, tcyc});
    end
  end

  // Drive at posedge+1; returns at posedge+1 of the accept edge with the request still asserted.
  task automatic do_req(input bit wr, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, output int acc_n);
    bit ok = 0;
    bit r;
    int n = 0;
    acc_n = -1;
    bus.data_req_valid = 1; bus.data_req_wr = wr; bus.data_req_size = sz;
    bus.data_req_addr = a; bus.data_req_data = d;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      r = bus.data_req_ready;
      n = tcyc;
      rdy_log = {rdy_log[30:0], r};
      rdy_n++;
      @(posedge clk); #1;
      if (r) begin acc_n = n; ok = 1; break; end
    end
    if (!ok) begin
      nchk++; nerr++;
      $display("FAIL req_timeout: request at addr %h never accepted", a);
    end
  endtask

  task automatic idle();
    bus.data_req_valid = 0;
    @(posedge clk); #1;
  endtask

  task automatic wait_obs(input int base, input int cnt, output bit ok);
    for (int t = 0; t < 40 && obs_a.size() < base + cnt; t++) @(posedge clk);
    #1;
    ok = obs_a.size() >= base + cnt;
    if (!ok) begin
      nchk++; nerr++;
      $display("FAIL rsp_timeout: got %0d responses expected %0d", obs_a.size() - base, cnt);
    end
  endtask

  task automatic load_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    int base, n;
    bit ok;
    base = obs_a.size();
    do_req(0, 2'd2, a, 32'h0, n);
    idle();
    wait_obs(base, 1, ok);
    if (ok) begin
      chk({nm, "_data"}, obs_a[base].data, exp);
      chk({nm, "_lat"}, obs_a[base].cyc - n, LAT);
    end
  endtask

  initial begin
    int n, n0, n1, n2, base;
    bit ok, wr;
    logic [1:0] sz;
    logic [31:0] a, d;
    bus.data_req_valid = 0; bus.data_req_wr = 0; bus.data_req_size = 0;
    bus.data_req_addr = 0; bus.data_req_data = 0;
    repeat (3) @(posedge clk); #1 reset = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) do_req(1, 2'd2, 32'(i*4), 32'(i+1), n);
    idle();

    do_req(1, 2'd2, 32'h10, 32'hDEADBEEF, n);
    load_chk("word_rw", 32'h10, 32'hDEADBEEF);

    do_req(1, 2'd2, 32'h20, 32'h0, n);
    do_req(1, 2'd0, 32'h23, 32'h000000AB, n);
    do_req(1, 2'd1, 32'h20, 32'h00001234, n);
    load_chk("lanes", 32'h20, 32'hAB001234);

    base = obs_a.size();
    do_req(0, 2'd2, 32'h0, 0, n0);
    do_req(0, 2'd2, 32'h4, 0, n1);
    do_req(0, 2'd2, 32'h8, 0, n2);
    idle();
    wait_obs(base, 3, ok);
    if (ok) begin
      chk("order0", obs_a[base].data, 32'd1);
      chk("order1", obs_a[base+1].data, 32'd2);
      chk("order2", obs_a[base+2].data, 32'd3);
      chk("lat0", obs_a[base].cyc - n0, LAT);
      chk("lat2", obs_a[base+2].cyc - n2, LAT);
      chk("b2b", obs_a[base+1].cyc - obs_a[base].cyc, 1);
    end

    reset = 0; @(posedge clk); @(posedge clk); #1 reset = 1;
    idle();
    rdy_log = 0; rdy_n = 0;
    do_req(1, 2'd2, 32'h34, 32'hA1A1A1A1, n);
    do_req(1, 2'd2, 32'h38, 32'hB2B2B2B2, n);
    do_req(1, 2'd2, 32'h3C, 32'hC3C3C3C3, n);
    do_req(1, 2'd2, 32'h2C, 32'hD4D4D4D4, n);
    do_req(1, 2'd2, 32'h28, 32'hE5E5E5E5, n);
    idle();
    chk("stall_samples", rdy_n, 7);
    chk("stall_pattern", {25'b0, rdy_log[6:0]}, {25'b0, 7'b1101101});
    load_chk("stall_ld", 32'h2C, 32'hD4D4D4D4);
    load_chk("stall_ld2", 32'h38, 32'hB2B2B2B2);

    do_req(1, 2'd2, 32'h31, 32'h55555555, n);
    idle();
    @(negedge clk);
    chk("mis_err", {31'b0, bus.err_misaligned}, 1);
    @(posedge clk); #1;
    load_chk("mis_nowrite", 32'h30, 32'h0000000D);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("mis_sticky", {31'b0, bus.err_misaligned}, 1);
    @(posedge clk); #1;

    base = obs_a.size();
    do_req(0, 2'd2, 32'h4, 0, n);
    bus.data_req_valid = 0;
    reset = 0;
    @(negedge clk);
    chk("mid_rst_ready", {31'b0, bus.data_req_ready}, 0);
    repeat (2) @(posedge clk); #1 reset = 1;
    @(negedge clk);
    chk("rel_ready0", {31'b0, bus.data_req_ready}, 0);
    @(negedge clk);
    chk("rel_ready1", {31'b0, bus.data_req_ready}, 1);
    repeat (6) @(negedge clk);
    chk("mid_rst_no_rsp", obs_a.size() - base, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 300; i++) begin
      a = $urandom & 32'hFFFF_F03F;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      sz = 2'($urandom_range(0, 3));
      wr = 1'($urandom_range(0, 1));
      d = $urandom;
      do_req(wr, sz, a, d, n);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    repeat (10) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
